trace_buffer_ctrl: RTL and testbench

TRACE_BUFFER_CTRL -- requirements
Module: trace_buffer_ctrl

---
 rtl/trace_buffer_ctrl_if.sv | 23 ++
 rtl/trace_buffer_ctrl.sv | 141 ++++++++++++++
 tb/tb_trace_buffer_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/trace_buffer_ctrl_if.sv
// BRAM port bundle between the trace buffer controller (master) and the dual-port trace RAM (slave).
interface trace_buffer_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 15
) ();
  logic [ADDR_WIDTH-1:0] trace_buf_bram_addra;
  logic                  trace_buf_we;
  logic [ADDR_WIDTH-1:0] trace_buf_bram_addrb;
  logic                  trace_buf_en;

  modport master (
    output trace_buf_bram_addra,
    output trace_buf_we,
    output trace_buf_bram_addrb,
    output trace_buf_en
  );

  modport slave (
    input trace_buf_bram_addra,
    input trace_buf_we,
    input trace_buf_bram_addrb,
    input trace_buf_en
  );
endinterface

// File: rtl/trace_buffer_ctrl.sv
// Trace capture controller: writes sampled data into a circular BRAM, with optional
// triggered stop after post_len samples, and generates an offset-relative read address.
module trace_buffer_ctrl #(
  parameter int unsigned TRACE_BUF_ADDR_WIDTH = 15,
  parameter int unsigned OFFSET_WIDTH         = 32
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            sample_valid,
  input  logic                            mode,
  input  logic                            arm,
  input  logic                            clear,
  input  logic                            trigger,
  input  logic [TRACE_BUF_ADDR_WIDTH-1:0] post_len,
  input  logic [OFFSET_WIDTH-1:0]         rd_offset,
  trace_buffer_ctrl_if.master             bram,
  output logic [1:0]                      state,
  output logic [TRACE_BUF_ADDR_WIDTH-1:0] trig_addr,
  output logic                            wrapped,
  output logic                            done
);

  localparam int unsigned AW = TRACE_BUF_ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_POST = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] addra_q, addra_d;
  logic [AW-1:0] addrb_q, addrb_d;
  logic [AW-1:0] trig_addr_q, trig_addr_d;
  logic [AW-1:0] remaining_q, remaining_d;
  logic          we_q, we_d;
  logic          wrapped_q, wrapped_d;
  logic          mode_q, mode_d;
  logic          wr_c;
  logic [AW-1:0] base_c;
  logic          unused_offset_hi;

  // Only the low address bits of the software offset matter; the rest wraps away.
  assign unused_offset_hi = ^rd_offset;

  assign wr_c   = sample_valid && !clear && ((state_q == ST_PRE) || (state_q == ST_POST));
  assign base_c = (state_q == ST_DONE) ? trig_addr_q : wr_ptr_q;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    addra_d     = addra_q;
    addrb_d     = base_c + rd_offset[AW-1:0];
    trig_addr_d = trig_addr_q;
    remaining_d = remaining_q;
    we_d        = 1'b0;
    wrapped_d   = wrapped_q;
    mode_d      = mode_q;

    if (wr_c) begin
      we_d     = 1'b1;
      addra_d  = wr_ptr_q;
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (&wr_ptr_q) begin
        wrapped_d = 1'b1;
      end
    end

    // clear wins over arm, arm over trigger
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            state_d   = ST_PRE;
            wr_ptr_d  = '0;
            wrapped_d = 1'b0;
            mode_d    = mode;
          end
        end
        ST_PRE: begin
          if (mode_q && sample_valid && trigger) begin
            trig_addr_d = wr_ptr_q;
            if (post_len == '0) begin
              state_d = ST_DONE;
            end else begin
              state_d     = ST_POST;
              remaining_d = post_len;
            end
          end
        end
        ST_POST: begin
          if (sample_valid) begin
            remaining_d = remaining_q - AW'(1);
            if (remaining_q == AW'(1)) begin
              state_d = ST_DONE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      addra_q     <= '0;
      addrb_q     <= '0;
      trig_addr_q <= '0;
      remaining_q <= '0;
      we_q        <= 1'b0;
      wrapped_q   <= 1'b0;
      mode_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      addra_q     <= addra_d;
      addrb_q     <= addrb_d;
      trig_addr_q <= trig_addr_d;
      remaining_q <= remaining_d;
      we_q        <= we_d;
      wrapped_q   <= wrapped_d;
      mode_q      <= mode_d;
    end
  end

  assign bram.trace_buf_bram_addra = addra_q;
  assign bram.trace_buf_we         = we_q;
  assign bram.trace_buf_bram_addrb = addrb_q;
  assign bram.trace_buf_en         = 1'b1;
  assign state                     = 2'(state_q);
  assign done                      = (state_q == ST_DONE);
  assign trig_addr                 = trig_addr_q;
  assign wrapped                   = wrapped_q;

endmodule

// File: tb/tb_trace_buffer_ctrl.sv
// Self-checking bench for trace_buffer_ctrl: write addresses/latency via scoreboard, control state via direct checks.
module tb_trace_buffer_ctrl;
  localparam int unsigned AW    = 4;
  localparam int unsigned OW    = 32;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rstn, sample_valid, mode, arm, clear, trigger;
  logic [AW-1:0] post_len;
  logic [OW-1:0] rd_offset;
  logic [1:0]    state;
  logic [AW-1:0] trig_addr;
  logic          wrapped, done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;
  int unsigned mdl_ptr = 0;
  logic [AW-1:0] exp_addr_q[$];
  int            exp_cyc_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  trace_buffer_ctrl_if #(.ADDR_WIDTH(AW)) bram_if ();

  trace_buffer_ctrl #(
    .TRACE_BUF_ADDR_WIDTH(AW),
    .OFFSET_WIDTH        (OW)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .sample_valid(sample_valid),
    .mode        (mode),
    .arm         (arm),
    .clear       (clear),
    .trigger     (trigger),
    .post_len    (post_len),
    .rd_offset   (rd_offset),
    .bram        (bram_if.master),
    .state       (state),
    .trig_addr   (trig_addr),
    .wrapped     (wrapped),
    .done        (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One sample strobe; a write is expected one cycle later at the model pointer when exp_wr.
  task automatic sample(input logic trig, input logic exp_wr);
    sample_valid = 1'b1;
    trigger      = trig;
    if (exp_wr) begin
      exp_addr_q.push_back(AW'(mdl_ptr));
      exp_cyc_q.push_back(cyc_cnt + 1);
      mdl_ptr = (mdl_ptr + 1) % DEPTH;
    end
    step();
    sample_valid = 1'b0;
    trigger      = 1'b0;
  endtask

  task automatic pulse_arm(input logic m, input logic [AW-1:0] pl);
    mode     = m;
    post_len = pl;
    arm      = 1'b1;
    step();
    arm     = 1'b0;
    mdl_ptr = 0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  // Write-port monitor: every we must match the next scoreboard entry in address and cycle.
  always @(negedge clk) begin
    if (bram_if.trace_buf_we === 1'b1) begin
      if (exp_addr_q.size() == 0) begin
        check_eq("we_spurious", 32'(bram_if.trace_buf_we), 32'd0);
      end else begin
        check_eq("addra", 32'(bram_if.trace_buf_bram_addra), 32'(exp_addr_q.pop_front()));
        check_eq("we_latency", 32'(cyc_cnt), 32'(exp_cyc_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; sample_valid = 1'b0; mode = 1'b0; arm = 1'b0; clear = 1'b0;
    trigger = 1'b0; post_len = '0; rd_offset = '0;
    step(); step();
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_we", 32'(bram_if.trace_buf_we), 32'd0);
    check_eq("rst_addra", 32'(bram_if.trace_buf_bram_addra), 32'd0);
    check_eq("rst_addrb", 32'(bram_if.trace_buf_bram_addrb), 32'd0);
    check_eq("rst_trig_addr", 32'(trig_addr), 32'd0);
    check_eq("rst_wrapped", 32'(wrapped), 32'd0);
    check_eq("bram_en", 32'(bram_if.trace_buf_en), 32'd1);
    rstn = 1'b1;
    step();

    // free-run: five back-to-back samples, trigger ignored
    pulse_arm(1'b0, '0);
    check_eq("fr_state_pre", 32'(state), 32'd1);
    for (int i = 0; i < 5; i++) sample(1'b0, 1'b1);
    step();
    check_eq("fr_state_hold", 32'(state), 32'd1);
    check_eq("fr_done", 32'(done), 32'd0);
    sample(1'b1, 1'b1);
    check_eq("fr_trig_ignored", 32'(state), 32'd1);
    step();

    // wrap in free-run; arm in PRE must not reset the pointer
    pulse_clear();
    check_eq("clr_idle", 32'(state), 32'd0);
    pulse_arm(1'b0, '0);
    for (int i = 0; i < 15; i++) sample(1'b0, 1'b1);
    check_eq("wrap_pre", 32'(wrapped), 32'd0);
    sample(1'b0, 1'b1);
    check_eq("wrap_set", 32'(wrapped), 32'd1);
    sample(1'b0, 1'b1);
    check_eq("wrap_sticky", 32'(wrapped), 32'd1);
    rd_offset = 32'd3;
    step();
    check_eq("addrb_pre", 32'(bram_if.trace_buf_bram_addrb), 32'd4);
    rd_offset = '0;
    arm = 1'b1;
    sample(1'b0, 1'b1);
    arm = 1'b0;
    sample(1'b0, 1'b1);
    check_eq("arm_in_pre", 32'(state), 32'd1);

    // triggered: trigger on 6th sample, post_len=3, mode change after arm ignored
    pulse_clear();
    pulse_arm(1'b1, AW'(3));
    mode = 1'b0;
    for (int i = 0; i < 5; i++) sample(1'b0, 1'b1);
    sample(1'b1, 1'b1);
    check_eq("trg_state_post", 32'(state), 32'd2);
    check_eq("trg_addr5", 32'(trig_addr), 32'd5);
    sample(1'b0, 1'b1);
    step();
    check_eq("post_gap", 32'(state), 32'd2);
    sample(1'b0, 1'b1);
    check_eq("post_not_yet", 32'(state), 32'd2);
    sample(1'b0, 1'b1);
    check_eq("post_done_state", 32'(state), 32'd3);
    check_eq("post_done", 32'(done), 32'd1);
    sample(1'b0, 1'b0);
    sample(1'b1, 1'b0);
    check_eq("done_trig_ignored", 32'(trig_addr), 32'd5);
    rd_offset = 32'hFFFF_FFFE;
    step();
    check_eq("addrb_done_wrap", 32'(bram_if.trace_buf_bram_addrb), 32'd3);
    rd_offset = '0;

    // re-arm from DONE, post_len=0: trigger sample goes straight to DONE
    pulse_arm(1'b1, '0);
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    check_eq("trig_no_sv", 32'(state), 32'd1);
    sample(1'b0, 1'b1);
    sample(1'b0, 1'b1);
    sample(1'b1, 1'b1);
    check_eq("pl0_state", 32'(state), 32'd3);
    check_eq("pl0_done", 32'(done), 32'd1);
    check_eq("pl0_trig_addr", 32'(trig_addr), 32'd2);
    step();
    check_eq("pl0_last_addra", 32'(bram_if.trace_buf_bram_addra), 32'd2);

    // clear and arm together in POST
    pulse_arm(1'b1, AW'(5));
    sample(1'b1, 1'b1);
    check_eq("ca_post", 32'(state), 32'd2);
    clear = 1'b1;
    arm   = 1'b1;
    step();
    clear = 1'b0;
    arm   = 1'b0;
    check_eq("ca_idle", 32'(state), 32'd0);
    check_eq("ca_done", 32'(done), 32'd0);

    // reset during POST discards capture
    pulse_arm(1'b1, AW'(4));
    for (int i = 0; i < 3; i++) sample(1'b0, 1'b1);
    sample(1'b1, 1'b1);
    check_eq("rp_trig_addr", 32'(trig_addr), 32'd3);
    rstn = 1'b0;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    check_eq("rp_we", 32'(bram_if.trace_buf_we), 32'd0);
    check_eq("rp_state", 32'(state), 32'd0);
    check_eq("rp_addra", 32'(bram_if.trace_buf_bram_addra), 32'd0);
    check_eq("rp_addrb", 32'(bram_if.trace_buf_bram_addrb), 32'd0);
    check_eq("rp_trig_addr0", 32'(trig_addr), 32'd0);
    check_eq("rp_wrapped", 32'(wrapped), 32'd0);
    check_eq("rp_done", 32'(done), 32'd0);
    rstn = 1'b1;
    step();
    sample(1'b0, 1'b0);
    check_eq("rp_idle_after", 32'(state), 32'd0);

    step(); step();
    check_eq("sb_drain", 32'(exp_addr_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
